// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- 32-entry register file with two registered read ports.
//
// The file has one write port and two read ports. Reads take one cycle and
// have a write-first bypass. Register 0 always reads as zero. A saturating
// counter tracks how many writes were accepted.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   we       in   1      write enable
//   waddr    in   5      write address (a write to address 0 is discarded)
//   wdata    in   WIDTH  write data
//   rd_en    in   1      read request; the result appears after the next edge
//   raddr1   in   5      read address, port 1
//   raddr2   in   5      read address, port 2
//   rdata1   out  WIDTH  registered read data, port 1 (held while idle)
//   rdata2   out  WIDTH  registered read data, port 2 (held while idle)
//   rvalid   out  1      one-cycle flag: rdata1/rdata2 hold a fresh result
//   wr_count out  8      accepted writes since reset, saturating at 255
// ---------------------------------------------------------------------------
module reg_file #(
   parameter int WIDTH = 32,
   parameter int NREG  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_en,
   input  logic [4:0]       raddr1,
   input  logic [4:0]       raddr2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2,
   output logic             rvalid,
   output logic [7:0]       wr_count
);

   logic [WIDTH-1:0] regs [NREG];

   // Bit-column view of the storage. col[k] gathers bit k of every register,
   // which is the form the downstream per-bit 32:1 selects consume.
   logic [NREG-1:0]  col [WIDTH];

   logic [WIDTH-1:0] rd1_mux, rd2_mux;
   logic [WIDTH-1:0] rd1_next, rd2_next;
   logic             wr_acc;

   // The whole condition is guarded by we. Unknown address or data values
   // while we=0 therefore cannot turn into an accepted write.
   assign wr_acc = we && (waddr != 5'd0);

   // Register array. Entry 0 is cleared on reset and is never written, so it
   // reads as zero at all times.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_acc) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         col[k] = '0;
         for (int r = 0; r < NREG; r++) begin
            col[k][r] = regs[r][k];
         end
      end
   end

   always_comb begin
      rd1_mux = '0;
      rd2_mux = '0;
      for (int k = 0; k < WIDTH; k++) begin
         rd1_mux[k] = col[k][raddr1];
         rd2_mux[k] = col[k][raddr2];
      end
   end

   // Write-first bypass, applied to each port on its own. Address 0 is forced
   // to zero first. wr_acc already excludes address 0, so the explicit test
   // only keeps the intent obvious to a reader.
   always_comb begin
      rd1_next = rd1_mux;
      rd2_next = rd2_mux;
      if (raddr1 == 5'd0) begin
         rd1_next = '0;
      end else if (wr_acc && (waddr == raddr1)) begin
         rd1_next = wdata;
      end
      if (raddr2 == 5'd0) begin
         rd2_next = '0;
      end else if (wr_acc && (waddr == raddr2)) begin
         rd2_next = wdata;
      end
   end

   // Read pipeline stage: the data is captured only on a request, so the
   // outputs hold their value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata1 <= '0;
         rdata2 <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            rdata1 <= rd1_next;
            rdata2 <= rd2_next;
         end
      end
   end

   // Saturating write counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= 8'd0;
      end else if (wr_acc && (wr_count != 8'hFF)) begin
         wr_count <= wr_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        rd_en;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic        rvalid;
   logic [7:0]  wr_count;

   int n_tests;
   int n_fail;

   reg_file #(.WIDTH(32), .NREG(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rd_en    (rd_en),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .rvalid   (rvalid),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        rd_en;
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
      logic [31:0] exp_r1;
      logic [31:0] exp_r2;
      logic        exp_rv;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Apply inputs, then sample 1 time unit after the rising edge.
   task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r, input logic [4:0] ra1, input logic [4:0] ra2);
      we = w; waddr = wa; wdata = wd; rd_en = r; raddr1 = ra1; raddr2 = ra2;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic erv, input logic [7:0] ecnt);
      check({tag, ".rdata1"}, rdata1, e1);
      check({tag, ".rdata2"}, rdata2, e2);
      check({tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, erv});
      check({tag, ".wr_count"}, {24'd0, wr_count}, {24'd0, ecnt});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;

      //               we  waddr  wdata          rd  ra1    ra2    exp_r1         exp_r2         rv    cnt
      vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd31, 32'h0,        32'h0,        1'b1, 8'd0};
      vecs[1]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 8'd1};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        1'b1, 8'd1};
      vecs[3]  = '{1'b1, 5'd9,  32'h12345678, 1'b1, 5'd9,  5'd9,  32'h12345678, 32'h12345678, 1'b1, 8'd2};
      vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 1'b1, 8'd2};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'h0,        32'hDEADBEEF, 1'b0, 8'd2};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd9,  32'h0,        32'h12345678, 1'b1, 8'd2};
      vecs[7]  = '{1'b1, 5'd9,  32'hAAAA5555, 1'b1, 5'd9,  5'd7,  32'hAAAA5555, 32'hDEADBEEF, 1'b1, 8'd3};
      vecs[8]  = '{1'b1, 5'd7,  32'h01020304, 1'b1, 5'd9,  5'd7,  32'hAAAA5555, 32'h01020304, 1'b1, 8'd4};
      vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        1'b1, 8'd5};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd9,  32'hCAFEF00D, 32'hAAAA5555, 1'b1, 8'd5};

      we = 0; waddr = 0; wdata = 0; rd_en = 0; raddr1 = 0; raddr2 = 0;
      rst_n = 1'b0;
      #1;
      check_all("reset", 32'h0, 32'h0, 1'b0, 8'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;

      for (int i = 0; i < 11; i++) begin
         step(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].rd_en, vecs[i].raddr1, vecs[i].raddr2);
         check_all($sformatf("vec%0d", i), vecs[i].exp_r1, vecs[i].exp_r2, vecs[i].exp_rv, vecs[i].exp_cnt);
      end

      // Unknown inputs with both enables low must leave every output unchanged.
      step(1'b0, 5'bxxxxx, 32'hxxxxxxxx, 1'b0, 5'bxxxxx, 5'bxxxxx);
      check_all("xidle", 32'hCAFEF00D, 32'hAAAA5555, 1'b0, 8'd5);

      // Counter saturation: 5 writes so far. After 249 more the count is 254,
      // after 250 it is 255, and it stays at 255 up to 300 writes.
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, 5'd3, i, 1'b0, 5'd0, 5'd0);
         if (i == 249) check("cnt_254", {24'd0, wr_count}, 32'd254);
         if (i == 250) check("cnt_255", {24'd0, wr_count}, 32'd255);
      end
      check("cnt_sat", {24'd0, wr_count}, 32'd255);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7);
      check_all("reg3_last", 32'd300, 32'h01020304, 1'b1, 8'd255);

      // Asynchronous reset in the middle of a read stream.
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd3);
      check_all("pre_rst", 32'hCAFEF00D, 32'd300, 1'b1, 8'd255);
      #2 rst_n = 1'b0;
      #1;
      check_all("async_rst", 32'h0, 32'h0, 1'b0, 8'd0);
      step(1'b1, 5'd5, 32'h55555555, 1'b1, 5'd5, 5'd31);
      check_all("in_rst", 32'h0, 32'h0, 1'b0, 8'd0);
      #2 rst_n = 1'b1;
      #1;
      check_all("post_rel", 32'h0, 32'h0, 1'b0, 8'd0);

      // The first edge after release behaves as a normal edge: every register
      // reads zero, and the write attempted during reset left no trace.
      for (int a = 0; a < 32; a++) begin
         step(1'b0, 5'd0, 32'h0, 1'b1, a[4:0], 5'd31 - a[4:0]);
         check($sformatf("clr_r1_%0d", a), rdata1, 32'h0);
         check($sformatf("clr_r2_%0d", a), rdata2, 32'h0);
         check($sformatf("clr_rv_%0d", a), {31'd0, rvalid}, 32'd1);
      end
      check("clr_cnt", {24'd0, wr_count}, 32'd0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      check("rv_drop", {31'd0, rvalid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
